pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 16-bit, 5-stage pipelined datapath.
- Keeps a scoreboard of in-flight destination registers for stages EX..WB (DEPTH entries), compared against the ID-stage sources.
- Produces operand-forward selects, load-use stalls, branch/jump flushes and a halt-drain sequence.
- Sits beside the ID stage and drives the PC, IF/ID and ID/EX register controls.

Parameters:
- REG_AW, 4, register address width (16 registers).
- DEPTH, 3, scoreboard stages from EX to WB inclusive; legal range 2..7; stage 1 = EX, stage DEPTH = WB.
- SEL_W, $clog2(DEPTH+1), width of the forward-stage select.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- id_valid  in  1  a real instruction is present in ID.
- id_src1, id_src2  in  REG_AW  source register addresses.
- id_src1_used, id_src2_used  in  1  the source is actually read.
- id_dst1, id_dst2  in  REG_AW  destination addresses (dst1 takes result[15:0], dst2 takes result[31:16]).
- id_we1, id_we2  in  1  destination write enables.
- id_is_load  in  1  result is not ready until the end of stage 2.
- id_halt  in  1  the ID instruction is HALT.
- ex_redirect  in  1  a taken branch or jump was resolved in EX.
- pc_stall  out  1  hold the PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  clear IF/ID to a NOP.
- idex_bubble  out  1  load a NOP into ID/EX.
- fwd1_stage, fwd2_stage  out  SEL_W  0 = register file, k = scoreboard stage k.
- fwd1_hi, fwd2_hi  out  1  take result[31:16] from the selected stage.
- halted  out  1  pipeline is drained after HALT.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Scoreboard entry fields: valid, dst1, we1, dst2, we2, is_load.
- Each cycle the scoreboard shifts: stage k+1 <= stage k.
  - Stage 1 <= the ID instruction when it issues; otherwise a bubble (valid = 0).
  - The WB entry drops out after one cycle.
- Issue condition: id_valid & !stall & !ex_redirect & state==RUN.
- Match rule for a source against a valid entry:
  - (src==dst1 & we1) or (src==dst2 & we2).
  - If both destinations match, dst1 wins (hi = 0).
  - The nearest stage (lowest k) wins.
- Forwarding, for each used source:
  - fwdN_stage = k of the nearest match, 0 if no match.
  - fwdN_hi = 1 when the match was on dst2.
  - Outputs are combinational, in the same cycle.
- Load-use stall: a used source that matches stage 1 with is_load = 1.
  - Asserts pc_stall = ifid_stall = idex_bubble = 1 for exactly one cycle.
  - The next cycle forwards from stage 2.
- Redirect, with priority over stall and halt:
  - ifid_flush = 1 and idex_bubble = 1.
  - pc_stall = 0, so the PC loads the target.
  - The ID instruction is killed; the EX entry (the branch itself) is kept.
- Halt FSM:
  - RUN: a HALT that issues (issue condition true) goes to DRAIN. A HALT that is stalled or redirected is not accepted.
  - DRAIN: pc_stall = ifid_stall = idex_bubble = 1. Go to HALTED when all scoreboard valids are 0.
  - HALTED: halted = 1 and all stalls held. Leave only via rst.
- The HALT instruction itself enters the scoreboard as a non-writing entry.
- A source whose address is unused (srcN_used = 0) never stalls or forwards.
- Reset: all scoreboard valids 0; state RUN; every output 0 (fwd selects 0, halted 0).
- Reset mid-drain returns to RUN with an empty scoreboard.

Optional Feature:
- Macro: PIPE_HAZARD_FWD_EN.
- Defined: forwarding as described above.
- Undefined:
  - fwd*_stage = 0 and fwd*_hi = 0 always.
  - Any used-source match in any stage stalls (pc_stall/ifid_stall/idex_bubble) until the producer has left WB.
  - Redirect and halt are unchanged.

Decomposition:
- Shared package pipe_pkg holds:
  - the scoreboard entry struct (sb_entry_t);
  - the halt FSM state enum (RUN, DRAIN, HALTED);
  - the NOP instruction constant;
  - FWD_NONE = 0.
- One natural sub-module: sb_match.
  - Combinational; compares one source against all DEPTH entries.
  - Returns match, stage, hi and load_hit.
  - Instantiated twice, once per source.

Test Plan:
- RAW chain, DEPTH=3: I0 writes R3 (we1); I1 reads R3 next cycle -> fwd1_stage=1, hi=0, no stall. The following cycle a read of R3 -> stage 2.
- Load-use: load to R5 then an immediate read of R5 -> one cycle of pc_stall/ifid_stall/idex_bubble=1, then fwd_stage=2. Total 1 bubble.
- Dual write: producer with dst1=R2, dst2=R15, consumer reads R15 -> fwd2_hi=1. With dst1=dst2=R4, a read of R4 gives hi=0.
- Redirect while a load-use stall is pending -> ifid_flush=1, idex_bubble=1, pc_stall=0. The killed instruction never appears in the scoreboard.
- HALT issued with 2 older writers in flight -> DRAIN for 3 cycles, then halted=1 and held. rst in DRAIN -> RUN with all outputs 0 the next cycle.
- Build without PIPE_HAZARD_FWD_EN: RAW at distance 1 -> 3 stall cycles, fwd selects stay 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline hazard controller.
//   sb_entry_t    - one scoreboard entry (an in-flight instruction's destinations)
//   halt_state_t  - halt / drain FSM states
//   NOP_INSTR     - encoding of the NOP instruction loaded on flush/bubble
//   SB_NOP        - empty scoreboard entry (bubble)
//   FWD_NONE      - forward select meaning "use the register file"
//   dst_hit()     - one source-vs-destination comparison
package pipe_pkg;

    localparam int REG_AW_P = 4;

    typedef struct packed {
        logic                valid;
        logic [REG_AW_P-1:0] dst1;
        logic                we1;
        logic [REG_AW_P-1:0] dst2;
        logic                we2;
        logic                is_load;
    } sb_entry_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam sb_entry_t   SB_NOP    = '0;
    localparam int          FWD_NONE  = 0;

    // A source hits a destination only when that destination is written.
    function automatic logic dst_hit(input logic [REG_AW_P-1:0] src,
                                     input logic [REG_AW_P-1:0] dst,
                                     input logic                we);
        return we && (src == dst);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sb_match.sv
// sb_match: compares one ID-stage source against every scoreboard entry.
//   src, used  - source address and whether it is actually read
//   sb         - scoreboard, index 0 = stage 1 (EX), index DEPTH-1 = WB
//   match      - some valid entry writes src
//   stage      - 1-based stage of the nearest matching entry (0 if none)
//   hi         - the nearest match was on dst2 only (dst1 wins a tie)
//   load_hit   - the nearest match is a load sitting in stage 1
module sb_match
    import pipe_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic [REG_AW_P-1:0]   src,
    input  logic                  used,
    input  sb_entry_t [DEPTH-1:0] sb,
    output logic                  match,
    output logic [SEL_W-1:0]      stage,
    output logic                  hi,
    output logic                  load_hit
);

    // Nearest-match search: walk from WB toward EX so a nearer hit overwrites.
    always_comb begin
        match    = 1'b0;
        stage    = SEL_W'(FWD_NONE);
        hi       = 1'b0;
        load_hit = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (used && sb[k].valid &&
                (dst_hit(src, sb[k].dst1, sb[k].we1) || dst_hit(src, sb[k].dst2, sb[k].we2))) begin
                match    = 1'b1;
                stage    = SEL_W'(k + 1);
                hi       = !dst_hit(src, sb[k].dst1, sb[k].we1);
                load_hit = sb[k].is_load && (k == 0);
            end else begin
                // no hit here: the result from a farther stage stands
                match    = match;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard / forwarding controller for the 5-stage pipeline.
// Inputs : clk, rst (sync, active-high), ID-stage instruction description
//          (id_valid, id_src*/id_src*_used, id_dst*/id_we*, id_is_load,
//          id_halt) and ex_redirect from the branch unit.
// Outputs: pc_stall, ifid_stall, ifid_flush, idex_bubble (pipeline register
//          controls), fwd*_stage / fwd*_hi (operand forward selects),
//          halted (pipeline drained after HALT).
// Build option: PIPE_HAZARD_FWD_EN enables forwarding; without it every
// used-source match stalls until the producer has left WB.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src1_used,
    input  logic              id_src2_used,
    input  logic [REG_AW-1:0] id_dst1,
    input  logic [REG_AW-1:0] id_dst2,
    input  logic              id_we1,
    input  logic              id_we2,
    input  logic              id_is_load,
    input  logic              id_halt,
    input  logic              ex_redirect,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [SEL_W-1:0]  fwd1_stage,
    output logic [SEL_W-1:0]  fwd2_stage,
    output logic              fwd1_hi,
    output logic              fwd2_hi,
    output logic              halted
);

    sb_entry_t [DEPTH-1:0] sb_q, sb_d;
    halt_state_t           state_q, state_d;
    logic                  halted_q, halted_d;

    logic                  m1_match, m2_match;
    logic [SEL_W-1:0]      m1_stage, m2_stage;
    logic                  m1_hi, m2_hi;
    logic                  m1_load, m2_load;
    logic                  hazard_s;
    logic                  issue_s;
    logic                  sb_next_busy_s;
    sb_entry_t             new_entry_s;

    sb_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match1 (
        .src      (id_src1),
        .used     (id_src1_used),
        .sb       (sb_q),
        .match    (m1_match),
        .stage    (m1_stage),
        .hi       (m1_hi),
        .load_hit (m1_load)
    );

    sb_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match2 (
        .src      (id_src2),
        .used     (id_src2_used),
        .sb       (sb_q),
        .match    (m2_match),
        .stage    (m2_stage),
        .hi       (m2_hi),
        .load_hit (m2_load)
    );

`ifdef PIPE_HAZARD_FWD_EN
    // Only a load still in EX cannot be forwarded; everything else is bypassed.
    always_comb begin
        hazard_s   = id_valid && (m1_load || m2_load);
        fwd1_stage = m1_match ? m1_stage : SEL_W'(FWD_NONE);
        fwd2_stage = m2_match ? m2_stage : SEL_W'(FWD_NONE);
        fwd1_hi    = m1_match && m1_hi;
        fwd2_hi    = m2_match && m2_hi;
    end
`else
    logic fwd_unused_s;

    // No bypass network: any in-flight producer of a used source blocks issue.
    always_comb begin
        hazard_s     = id_valid && (m1_match || m2_match);
        fwd1_stage   = SEL_W'(FWD_NONE);
        fwd2_stage   = SEL_W'(FWD_NONE);
        fwd1_hi      = 1'b0;
        fwd2_hi      = 1'b0;
        fwd_unused_s = ^{m1_stage, m2_stage, m1_hi, m2_hi, m1_load, m2_load};
    end
`endif

    // Pipeline register controls; a redirect outranks a hazard stall in RUN.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_redirect) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (hazard_s) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                end else begin
                    pc_stall    = 1'b0;
                end
            end
            DRAIN, HALTED: begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end
            default: begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end
        endcase
    end

    // Issue decision and the entry the ID instruction would occupy in EX.
    always_comb begin
        issue_s             = id_valid && !hazard_s && !ex_redirect && (state_q == RUN);
        new_entry_s         = SB_NOP;
        new_entry_s.valid   = 1'b1;
        new_entry_s.dst1    = id_dst1;
        new_entry_s.dst2    = id_dst2;
        // HALT travels down the pipe but never writes a register
        new_entry_s.we1     = id_we1 && !id_halt;
        new_entry_s.we2     = id_we2 && !id_halt;
        new_entry_s.is_load = id_is_load;
    end

    // Scoreboard shift: new entry (or bubble) into EX, WB entry falls off.
    always_comb begin
        sb_d[0] = issue_s ? new_entry_s : SB_NOP;
        for (int k = 1; k < DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end
        sb_next_busy_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            sb_next_busy_s = sb_next_busy_s || sb_d[k].valid;
        end
    end

    // Halt FSM next state: drain ends once HALT itself has left WB.
    always_comb begin
        case (state_q)
            RUN: begin
                if (issue_s && id_halt) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (sb_next_busy_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = HALTED;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
        halted_d = (state_d == HALTED);
    end

    // Halt FSM state and its registered halted flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign halted = halted_q;

endmodule
